// File: rtl/cla_pkg.sv
// Shared constants and types for the two-level carry-lookahead adder.
package cla_pkg;

    localparam int GROUP_W = 4;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    function automatic int grp_count(input int width);
        return width / GROUP_W;
    endfunction

endpackage

// File: rtl/cla_group4.sv
// 4-bit flat lookahead block: sum bits plus group generate/propagate.
// Purely combinational; no latency, no flow control.
// Backpressure: none.
module cla_group4
    import cla_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       G,
    output logic       P
);

    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is a flat sum of products; no term feeds another carry.
    assign c[0] = ci;
    assign c[1] = g[0] | (p[0] & ci);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);

    assign s = p ^ c;

    assign G = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    assign P = &p;

endmodule

// File: rtl/cla_adder.sv
// Two-level carry-lookahead adder {cout,sum} = a+b+cin; optional ovf via CLA_OVERFLOW_EN.
// Latency: 1 cycle, one operation per cycle back-to-back.
// Backpressure: none; out_valid follows in_valid one clock later.
module cla_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
`ifdef CLA_OVERFLOW_EN
    output logic             ovf,
`endif
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NG = grp_count(WIDTH);
    localparam int NB = (NG + 3) / 4;

    if ((WIDTH % GROUP_W) != 0 || WIDTH < 4 || WIDTH > 64) begin : g_bad_width
        $error("cla_adder: WIDTH must be a multiple of 4 in 4..64");
    end

    gp_t             grp [NB*4];
    logic [NB*4:0]   gc;
    logic [WIDTH-1:0] sum_c;

    for (genvar i = 0; i < NB*4; i++) begin : g_grp
        if (i < NG) begin : g_real
            cla_group4 u_grp (
                .a  (a[i*GROUP_W +: GROUP_W]),
                .b  (b[i*GROUP_W +: GROUP_W]),
                .ci (gc[i]),
                .s  (sum_c[i*GROUP_W +: GROUP_W]),
                .G  (grp[i].g),
                .P  (grp[i].p)
            );
        end else begin : g_pad
            assign grp[i] = '0;
        end
    end

    // Second level: within a block of 4 groups each carry is a flat OR of
    // products over (block carry-in, group G/P); blocks chain their carry-out.
    always_comb begin
        logic [4:0] eg;
        logic [4:0] ep;
        logic       acc;
        logic       term;
        eg   = '0;
        ep   = '0;
        acc  = 1'b0;
        term = 1'b0;
        gc   = '0;
        gc[0] = cin;
        for (int blk = 0; blk < NB; blk++) begin
            eg[0] = gc[blk*4];
            ep[0] = 1'b0;
            for (int j = 1; j <= 4; j++) begin
                eg[j] = grp[blk*4 + j - 1].g;
                ep[j] = grp[blk*4 + j - 1].p;
            end
            for (int k = 1; k <= 4; k++) begin
                acc = 1'b0;
                for (int t = 0; t <= k; t++) begin
                    term = eg[t];
                    for (int u = t + 1; u <= k; u++) begin
                        term = term & ep[u];
                    end
                    acc = acc | term;
                end
                gc[blk*4 + k] = acc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
`ifdef CLA_OVERFLOW_EN
            ovf       <= 1'b0;
`endif
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum  <= sum_c;
                cout <= gc[NG];
`ifdef CLA_OVERFLOW_EN
                // Carry into the MSB recovered from its sum bit and operands.
                ovf  <= gc[NG] ^ (sum_c[WIDTH-1] ^ a[WIDTH-1] ^ b[WIDTH-1]);
`endif
            end
        end
    end

endmodule

// File: tb/tb_cla_adder.sv
// Bench for cla_adder at WIDTH 4/16/32 against an arithmetic reference model.
module tb_cla_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        cin;
    logic [3:0]  a4, b4;
    logic [15:0] a16, b16;
    logic [31:0] a32, b32;

    logic        ov4, ov16, ov32;
    logic [3:0]  s4;
    logic [15:0] s16;
    logic [31:0] s32;
    logic        co4, co16, co32;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic        e_vld;
    logic [3:0]  e_s4;
    logic [15:0] e_s16;
    logic [31:0] e_s32;
    logic        e_c4, e_c16, e_c32;
`ifdef CLA_OVERFLOW_EN
    logic        f4, f16, f32;
    logic        e_f4, e_f16, e_f32;
`endif

    always #5 clk = ~clk;

    cla_adder #(.WIDTH(4)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a4), .b(b4), .cin(cin),
        .out_valid(ov4),
`ifdef CLA_OVERFLOW_EN
        .ovf(f4),
`endif
        .sum(s4), .cout(co4));

    cla_adder #(.WIDTH(16)) u16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a16), .b(b16), .cin(cin),
        .out_valid(ov16),
`ifdef CLA_OVERFLOW_EN
        .ovf(f16),
`endif
        .sum(s16), .cout(co16));

    cla_adder #(.WIDTH(32)) u32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a32), .b(b32), .cin(cin),
        .out_valid(ov32),
`ifdef CLA_OVERFLOW_EN
        .ovf(f32),
`endif
        .sum(s32), .cout(co32));

    task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

`ifdef CLA_OVERFLOW_EN
    function automatic logic sovf(input longint sa, input longint sb, input logic c, input int w);
        longint r;
        longint lim;
        r   = sa + sb + longint'(c);
        lim = longint'(1) << (w - 1);
        return (r > lim - 1) || (r < -lim);
    endfunction
`endif

    // Model follows the stated rules directly: reset clears, valid loads a+b+cin, idle holds.
    task automatic model_update();
        logic [4:0]  t4;
        logic [16:0] t16;
        logic [32:0] t32;
        if (!rst_n) begin
            e_vld = 1'b0;
            e_s4 = '0; e_s16 = '0; e_s32 = '0;
            e_c4 = 1'b0; e_c16 = 1'b0; e_c32 = 1'b0;
`ifdef CLA_OVERFLOW_EN
            e_f4 = 1'b0; e_f16 = 1'b0; e_f32 = 1'b0;
`endif
        end else begin
            e_vld = in_valid;
            if (in_valid) begin
                t4  = {1'b0, a4}  + {1'b0, b4}  + 5'(cin);
                t16 = {1'b0, a16} + {1'b0, b16} + 17'(cin);
                t32 = {1'b0, a32} + {1'b0, b32} + 33'(cin);
                {e_c4, e_s4}   = t4;
                {e_c16, e_s16} = t16;
                {e_c32, e_s32} = t32;
`ifdef CLA_OVERFLOW_EN
                e_f4  = sovf(longint'($signed(a4)),  longint'($signed(b4)),  cin, 4);
                e_f16 = sovf(longint'($signed(a16)), longint'($signed(b16)), cin, 16);
                e_f32 = sovf(longint'($signed(a32)), longint'($signed(b32)), cin, 32);
`endif
            end
        end
    endtask

    task automatic cycle(input logic r, input logic v, input logic c,
                         input logic [3:0] x4, input logic [3:0] y4,
                         input logic [15:0] x16, input logic [15:0] y16,
                         input logic [31:0] x32, input logic [31:0] y32);
        @(negedge clk);
        rst_n = r; in_valid = v; cin = c;
        a4 = x4; b4 = y4; a16 = x16; b16 = y16; a32 = x32; b32 = y32;
        @(posedge clk);
        model_update();
        #1;
        chk("vld4",  33'(ov4),  33'(e_vld));
        chk("vld16", 33'(ov16), 33'(e_vld));
        chk("vld32", 33'(ov32), 33'(e_vld));
        chk("res4",  33'({co4, s4}),   33'({e_c4, e_s4}));
        chk("res16", 33'({co16, s16}), 33'({e_c16, e_s16}));
        chk("res32", {co32, s32},      {e_c32, e_s32});
`ifdef CLA_OVERFLOW_EN
        chk("ovf4",  33'(f4),  33'(e_f4));
        chk("ovf16", 33'(f16), 33'(e_f16));
        chk("ovf32", 33'(f32), 33'(e_f32));
`endif
    endtask

    initial begin
        logic [3:0]  r4a, r4b;
        logic [15:0] r16a, r16b;
        logic [31:0] r32a, r32b;
        rst_n = 1'b0; in_valid = 1'b0; cin = 1'b0;
        a4 = '0; b4 = '0; a16 = '0; b16 = '0; a32 = '0; b32 = '0;

        // Reset held with valid operands present
        cycle(0, 1, 1, 4'hF, 4'hF, 16'hFFFF, 16'hFFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        cycle(0, 1, 1, 4'hF, 4'hF, 16'hFFFF, 16'hFFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("rst_sum4_zero", 33'({co4, s4}), 33'd0);

        cycle(1, 1, 0, 4'h1, 4'h0, 16'h1, 16'h0, 32'h1, 32'h0);
        chk("first_sum4", 33'({co4, s4}), 33'd1);
        cycle(1, 1, 1, 4'h2, 4'h4, 16'h1234, 16'h4321, 32'h1234_5678, 32'h8765_4321);
        cycle(1, 1, 0, 4'hB, 4'h6, 16'h8000, 16'h8000, 32'h7FFF_FFFF, 32'h1);
        cycle(1, 1, 1, 4'h5, 4'h3, 16'h7FFF, 16'h0, 32'h0, 32'h0);
        cycle(1, 1, 1, 4'hF, 4'hF, 16'hFFFF, 16'hFFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("allones4", 33'({co4, s4}), 33'h1F);

        // Idle with X operands must hold the last result
        for (int i = 0; i < 3; i++)
            cycle(1, 0, 1'bx, 'x, 'x, 'x, 'x, 'x, 'x);
        chk("hold4", 33'({co4, s4}), 33'h1F);

        // Reset mid-stream discards the in-flight result
        cycle(1, 1, 0, 4'h7, 4'h8, 16'hAAAA, 16'h5555, 32'hDEAD_BEEF, 32'h1);
        cycle(0, 1, 1, 4'h3, 4'h3, 16'h3, 16'h3, 32'h3, 32'h3);
        cycle(1, 1, 0, 4'h0, 4'h0, 16'h0, 16'h0, 32'h0, 32'h0);

        for (int i = 0; i < 60; i++) begin
            r4a = 4'($urandom); r4b = 4'($urandom);
            r16a = 16'($urandom); r16b = 16'($urandom);
            r32a = $urandom; r32b = $urandom;
            cycle(1, 1, 1'($urandom), r4a, r4b, r16a, r16b, r32a, r32b);
        end

        cycle(1, 1, 1, 4'hF, 4'h0, 16'hFFFF, 16'h0, 32'hFFFF_FFFF, 32'h0);
        chk("wrap16", 33'({co16, s16}), 33'h1_0000);
        cycle(1, 1, 0, 4'hF, 4'h1, 16'hFFFF, 16'h1, 32'hFFFF_FFFF, 32'h1);
        chk("wrap32", {co32, s32}, 33'h1_0000_0000);
        cycle(1, 0, 0, 4'h0, 4'h0, 16'h0, 16'h0, 32'h0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
